mux16_rr_arbiter: RTL
=====================

Name: mux16_rr_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one 16:1 single-bit selection path among 16 requesters.
- Each requester i owns data line din[i]. The arbiter grants one requester at a time and drives the 4-bit select.
- While a grant is active, the selected bit is forwarded on q.
- Sits between the requesting agents and the shared single-bit output channel. Provides fairness and a bounded hold time.

Parameters:
- MAX_HOLD, 8, maximum consecutive grant cycles per tenure. Legal range 0..255. 0 = unlimited (no timeout).
- HOLD_W, 8, width of the hold counter. Must satisfy 2^HOLD_W > MAX_HOLD.

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, synchronous active-high reset.
- req, input, 16, request vector. Bit i high = requester i wants the channel.
- din, input, 16, data vector. Bit i is requester i's data.
- grant, output, 16, one-hot grant (registered). All-zero when no grant is active.
- sel, output, 4, index of the granted requester (registered).
- valid, output, 1, high while a grant is active (registered).
- q, output, 1, combinational: din[sel] when valid=1, else 0.

Behaviour:
- Reset values (sync, takes effect on the next clk edge while rst=1): state=IDLE, grant=16'h0000, sel=4'h0, valid=0, hold_cnt=0, last=4'hF. last=4'hF makes the first search start at index 0.
- Reset has priority over all other activity, including mid-grant. Grant drops on the edge at which rst is sampled high.
- States: IDLE and GRANT.
- IDLE:
  - If req==0, stay in IDLE; outputs hold their reset/idle values.
  - Else pick the winner: the first set bit of req scanning last+1, last+2, ... modulo 16.
  - On the next edge: state=GRANT, sel=winner, grant=1<<winner, valid=1, hold_cnt=0.
  - Request-to-grant latency is 1 cycle.
- GRANT:
  - Each cycle, evaluate release = (req[sel]==0) OR (MAX_HOLD!=0 AND hold_cnt==MAX_HOLD-1).
  - On release: next edge sets state=IDLE, grant=0, valid=0, last=sel. sel retains its value.
  - Otherwise: hold_cnt increments by 1. hold_cnt saturates at all-ones; saturation is only reachable when MAX_HOLD=0.
- Grant tenure:
  - Length is min(cycles req[sel] stays high, MAX_HOLD), and at least 1 cycle.
  - A mandatory 1-cycle IDLE gap follows every tenure; valid=0 for that cycle.
- A requester whose req drops within the 1-cycle arbitration window is not granted. Arbitration uses req as sampled in IDLE only.
- Changes in req bits other than req[sel] during GRANT have no effect until the next IDLE.
- Fairness: after requester k is served, every other requester that holds req high continuously is granted before k is granted again. The worst-case wait is 15 tenures plus 15 gaps.
- Single active requester: it is re-granted after each gap. With wrap-around the winner can be last itself.
- Invariants: grant is zero or one-hot; grant==(1<<sel) whenever valid=1; valid==|grant.

Optional Feature:
- Macro: MUX16_ARB_LOCK_EN.
- Defined:
  - Adds input port lock (1 bit).
  - While in GRANT with lock=1, the timeout term is masked: release = (req[sel]==0).
  - hold_cnt keeps counting (saturating).
  - If lock deasserts while hold_cnt ≥ MAX_HOLD-1, release occurs that same cycle, so grant drops on the next edge.
  - lock is ignored in IDLE.
- Not defined: no lock port; timeout always applies as above.

Test Plan:
- Reset mid-grant: req=16'h0010 granted (sel=4). Assert rst for 1 cycle → next edge grant=0, valid=0, sel=0, q=0. After release of rst with req=16'h0011, grant=16'h0001 (search restarts from index 0).
- Single requester, MAX_HOLD=8: req=16'h0020 held high, din[5]=1 → grant=16'h0020 for exactly 8 cycles with q=1. Then 1 cycle valid=0, then re-grant sel=5.
- Round-robin order: req=16'h8421 held high → grant sequence sel=0,5,10,15,0, each tenure 8 cycles separated by 1 idle cycle.
- Early release: req=16'h0003; requester 0 drops req after 3 grant cycles → grant=16'h0001 for 3 cycles, 1 idle, then grant=16'h0002. Wrap check: last=15, req=16'h8001 → winner 0.
- Unlimited hold (MAX_HOLD=0): req=16'h0100 held 300 cycles → grant never drops; hold_cnt saturates at 255 without wrap.
- MUX16_ARB_LOCK_EN defined, MAX_HOLD=4: req=16'h0006 with lock=1 held for 10 grant cycles → sel=1 for 10 cycles. lock→0 → grant drops on the next edge, 1 idle cycle, then sel=2.

Source files
------------

// File: rtl/mux16_rr_arbiter.sv
// mux16_rr_arbiter: round-robin arbiter sharing a 16:1 bit-select path, with bounded hold time.
// Optional lock input (masks the hold timeout) is enabled by defining MUX16_ARB_LOCK_EN.
module mux16_rr_arbiter #(
  parameter int MAX_HOLD = 8,
  parameter int HOLD_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] req,
  input  logic [15:0] din,
`ifdef MUX16_ARB_LOCK_EN
  input  logic        lock,
`endif
  output logic [15:0] grant,
  output logic [3:0]  sel,
  output logic        valid,
  output logic        q
);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t state;
  logic [HOLD_W-1:0] hold_cnt;
  logic [3:0] last, win, idx;
  logic found, timeout, rel;
  // Scan starts just past the last served index; i=16 wraps back onto last itself.
  always_comb begin
    win = '0;
    idx = '0;
    found = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      idx = last + 4'(i);
      if (!found && req[idx]) begin
        win = idx;
        found = 1'b1;
      end
    end
  end
`ifdef MUX16_ARB_LOCK_EN
  assign timeout = (MAX_HOLD != 0) && !lock && (hold_cnt >= HOLD_W'(MAX_HOLD - 1));
`else
  assign timeout = (MAX_HOLD != 0) && (hold_cnt >= HOLD_W'(MAX_HOLD - 1));
`endif
  assign rel = !req[sel] || timeout;
  assign q = valid & din[sel];
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      grant <= '0;
      sel <= '0;
      valid <= 1'b0;
      hold_cnt <= '0;
      last <= 4'hF;
    end else if (state == IDLE) begin
      if (found) begin
        state <= GRANT;
        sel <= win;
        grant <= 16'(1) << win;
        valid <= 1'b1;
        hold_cnt <= '0;
      end
    end else if (rel) begin
      state <= IDLE;
      grant <= '0;
      valid <= 1'b0;
      last <= sel;
    end else begin
      hold_cnt <= (&hold_cnt) ? hold_cnt : hold_cnt + 1'b1;
    end
  end
endmodule
